// File: rtl/alu_loop_sequencer_if.sv
// Shared types and the request/response bundle
// for the nibble-loop ALU sequencer.
package alu_loop_pkg;

  typedef logic [2:0] alu_cmd_t;

  localparam alu_cmd_t CMD_ADD  = 3'd0;
  localparam alu_cmd_t CMD_AND  = 3'd1;
  localparam alu_cmd_t CMD_OR   = 3'd2;
  localparam alu_cmd_t CMD_XOR  = 3'd3;
  localparam alu_cmd_t CMD_XNOR = 3'd4;

  typedef struct packed {
    alu_cmd_t cmd;
    logic     b_inv;
    logic     carry_disable;
  } AluCtrl;

  typedef struct packed {
    AluCtrl      ctrl;
    logic        carry_in;
    logic        eq_check;
    logic        signed_neg;
    logic [2:0]  nibbles;
    logic [31:0] word1;
    logic [31:0] word2;
    logic [31:0] preinit;
  } seq_req_t;

endpackage

interface alu_loop_sequencer_if;
  import alu_loop_pkg::*;

  logic        req_valid;
  logic        req_ready;
  AluCtrl      req_ctrl;
  logic        req_carry_in;
  logic        req_eq_check;
  logic        req_signed_neg;
  logic [2:0]  req_nibbles;
  logic [31:0] req_word1;
  logic [31:0] req_word2;
  logic [31:0] req_preinit;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_flag;
  logic        rsp_timeout;

  modport master (
    output req_valid,
    output req_ctrl,
    output req_carry_in,
    output req_eq_check,
    output req_signed_neg,
    output req_nibbles,
    output req_word1,
    output req_word2,
    output req_preinit,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_flag,
    input  rsp_timeout
  );

  modport slave (
    input  req_valid,
    input  req_ctrl,
    input  req_carry_in,
    input  req_eq_check,
    input  req_signed_neg,
    input  req_nibbles,
    input  req_word1,
    input  req_word2,
    input  req_preinit,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_flag,
    output rsp_timeout
  );

endinterface

// File: rtl/alu_loop_sequencer.sv
// Sequencer that arms, runs and watches a
// nibble-serial ALU loop, one request at a time.
module alu_loop_sequencer
  import alu_loop_pkg::*;
#(
  parameter int unsigned MAX_LOOP_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst_n,

  alu_loop_sequencer_if.slave bus,

  output logic        loop_perm_to_count,
  output logic [2:0]  loop_nibbles_number,
  output AluCtrl      loop_ctrl,
  output logic        loop_carry_in,
  output logic        loop_check_0xf,
  output logic        loop_signed_neg,
  output logic [31:0] loop_word1,
  output logic [31:0] loop_word2,
  output logic [31:0] loop_preinit,

  input  logic        loop_busy,
  input  logic [31:0] loop_result,
  input  logic        loop_carry_out
);

  localparam int unsigned CW =
    (MAX_LOOP_CYCLES < 2) ? 1 :
    $clog2(MAX_LOOP_CYCLES);

  localparam logic [CW-1:0] LAST =
    CW'(MAX_LOOP_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_d;
  seq_req_t      req_q;
  logic [CW-1:0] cnt;
  logic [31:0]   res_q;
  logic          flag_q;
  logic          tmo_q;

  logic is_idle;
  logic is_arm;
  logic is_run;
  logic is_resp;
  logic accept;
  logic run_done;
  logic run_tmo;

  assign is_idle = (state == IDLE);
  assign is_arm  = (state == ARM);
  assign is_run  = (state == RUN);
  assign is_resp = (state == RESP);

  assign accept = is_idle & bus.req_valid;

  // The first RUN edge is skipped: the loop
  // only sees perm_to_count=1 from that cycle,
  // so its busy flag is not yet meaningful.
  assign run_done = is_run
                  & (cnt != '0)
                  & ~loop_busy;

  assign run_tmo = is_run
                 & ~run_done
                 & (cnt == LAST);

  // Next-state decode
  always_comb begin
    state_d = state;
    unique case (1'b1)
      is_idle: begin
        if (bus.req_valid) state_d = ARM;
      end
      is_arm: begin
        state_d = RUN;
      end
      is_run: begin
        if (run_done | run_tmo) state_d = RESP;
      end
      is_resp: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Capture the request only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.ctrl       <= bus.req_ctrl;
      req_q.carry_in   <= bus.req_carry_in;
      req_q.eq_check   <= bus.req_eq_check;
      req_q.signed_neg <= bus.req_signed_neg;
      req_q.nibbles    <= bus.req_nibbles;
      req_q.word1      <= bus.req_word1;
      req_q.word2      <= bus.req_word2;
      req_q.preinit    <= bus.req_preinit;
    end
  end

  // Watchdog: zero on RUN entry, counts RUN edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (is_arm) begin
      cnt <= '0;
    end else if (is_run & ~run_done & ~run_tmo) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Response registers, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      flag_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else if (run_done) begin
      res_q  <= loop_result;
      flag_q <= loop_carry_out;
      tmo_q  <= 1'b0;
    end else if (run_tmo) begin
      res_q  <= loop_result;
      flag_q <= 1'b0;
      tmo_q  <= 1'b1;
    end
  end

  assign bus.req_ready   = is_idle;
  assign bus.rsp_valid   = is_resp;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_flag    = flag_q;
  assign bus.rsp_timeout = tmo_q;

  assign loop_perm_to_count  = is_run;
  assign loop_nibbles_number = req_q.nibbles;
  assign loop_ctrl           = req_q.ctrl;
  assign loop_carry_in       = req_q.carry_in;
  assign loop_check_0xf      = req_q.eq_check;
  assign loop_signed_neg     = req_q.signed_neg;
  assign loop_word1          = req_q.word1;
  assign loop_word2          = req_q.word2;
  assign loop_preinit        = req_q.preinit;

endmodule

// File: tb/tb_alu_loop_sequencer.sv
// Bench for alu_loop_sequencer with a
// nibble-serial loop stub and word-level model.
module tb_alu_loop_sequencer;
  import alu_loop_pkg::*;

  localparam int MAXC = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_loop_sequencer_if bus ();

  logic        loop_perm_to_count;
  logic [2:0]  loop_nibbles_number;
  AluCtrl      loop_ctrl;
  logic        loop_carry_in;
  logic        loop_check_0xf;
  logic        loop_signed_neg;
  logic [31:0] loop_word1;
  logic [31:0] loop_word2;
  logic [31:0] loop_preinit;
  logic        loop_busy;
  logic [31:0] loop_result;
  logic        loop_carry_out;

  alu_loop_sequencer #(
    .MAX_LOOP_CYCLES(MAXC)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .loop_perm_to_count (loop_perm_to_count),
    .loop_nibbles_number(loop_nibbles_number),
    .loop_ctrl          (loop_ctrl),
    .loop_carry_in      (loop_carry_in),
    .loop_check_0xf     (loop_check_0xf),
    .loop_signed_neg    (loop_signed_neg),
    .loop_word1         (loop_word1),
    .loop_word2         (loop_word2),
    .loop_preinit       (loop_preinit),
    .loop_busy          (loop_busy),
    .loop_result        (loop_result),
    .loop_carry_out     (loop_carry_out)
  );

  // Loop stub: one nibble per clock
  logic       stuck = 1'b0;
  logic [3:0] idx;
  logic [3:0] na;
  logic [3:0] nb;
  logic [4:0] ns;

  assign loop_busy = stuck ? 1'b1 :
    (loop_perm_to_count &&
     (idx <= {1'b0, loop_nibbles_number}));

  always @(posedge clk) begin
    if (!loop_perm_to_count) begin
      idx <= 4'd0;
      loop_result <= loop_preinit;
      loop_carry_out <= loop_check_0xf ?
        1'b1 : loop_carry_in;
    end else if (idx <=
        {1'b0, loop_nibbles_number}) begin
      na = loop_word1[int'(idx)*4 +: 4];
      nb = loop_word2[int'(idx)*4 +: 4];
      if (loop_ctrl.b_inv) nb = ~nb;
      if (loop_ctrl.cmd == CMD_XNOR) begin
        ns = {1'b0, ~(na ^ nb)};
        if (loop_check_0xf)
          loop_carry_out <= loop_carry_out
            & (ns[3:0] == 4'hF);
      end else begin
        ns = {1'b0, na} + {1'b0, nb}
           + {4'd0, loop_carry_out};
        loop_carry_out <= ns[4];
      end
      loop_result[int'(idx)*4 +: 4] <= ns[3:0];
      idx <= idx + 4'd1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Word-level reference
  function automatic void ref_model(
    input  alu_cmd_t    cmd,
    input  logic        cin,
    input  logic [2:0]  n,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [31:0] pre,
    output logic [31:0] res,
    output logic        flag
  );
    logic [32:0] sum;
    logic [31:0] mask;
    int          bits;
    bits = 4 * (int'(n) + 1);
    mask = (bits == 32) ? 32'hFFFF_FFFF :
           ((32'h1 << bits) - 32'h1);
    if (cmd == CMD_XNOR) begin
      res  = (pre & ~mask) | (~(w1 ^ w2) & mask);
      flag = (((w1 ^ w2) & mask) == 32'h0);
    end else begin
      sum  = {1'b0, w1 & mask}
           + {1'b0, w2 & mask}
           + {32'd0, cin};
      res  = (pre & ~mask) | (sum[31:0] & mask);
      flag = sum[bits];
    end
  endfunction

  task automatic drive_idle();
    bus.req_valid      = 1'b0;
    bus.req_ctrl       = '0;
    bus.req_carry_in   = 1'b0;
    bus.req_eq_check   = 1'b0;
    bus.req_signed_neg = 1'b0;
    bus.req_nibbles    = 3'd0;
    bus.req_word1      = '0;
    bus.req_word2      = '0;
    bus.req_preinit    = '0;
    bus.rsp_ready      = 1'b0;
  endtask

  task automatic do_req(
    input alu_cmd_t    cmd,
    input logic        cin,
    input logic [2:0]  n,
    input logic [31:0] w1,
    input logic [31:0] w2,
    input logic [31:0] pre,
    input int          hold,
    input logic        tmo
  );
    logic [31:0] eres;
    logic        eflag;
    logic [31:0] held;
    int          lat;
    int          perm;
    int          exp_lat;
    bit          seen;
    ref_model(cmd, cin, n, w1, w2, pre,
              eres, eflag);
    exp_lat = tmo ? (MAXC + 1) : (int'(n) + 3);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, bus.req_ready}, 1);
    bus.req_valid      = 1'b1;
    bus.req_ctrl.cmd   = cmd;
    bus.req_ctrl.b_inv = 1'b0;
    bus.req_ctrl.carry_disable = 1'b0;
    bus.req_carry_in   = cin;
    bus.req_eq_check   = (cmd == CMD_XNOR);
    bus.req_signed_neg = 1'b0;
    bus.req_nibbles    = n;
    bus.req_word1      = w1;
    bus.req_word2      = w2;
    bus.req_preinit    = pre;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_word1 = ~w1;
    lat  = 0;
    perm = 0;
    seen = 1'b0;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (loop_perm_to_count) begin
        perm++;
        if (!seen) begin
          seen = 1'b1;
          chk("loop_word1", loop_word1, w1);
        end
      end
    end
    if (lat >= 200) begin
      chk("rsp_wait_expired", 0, 1);
      return;
    end
    chk("latency", lat, exp_lat);
    chk("run_cycles", perm, exp_lat - 1);
    chk("rsp_result", bus.rsp_result, eres);
    chk("rsp_flag", {31'd0, bus.rsp_flag},
        tmo ? 32'd0 : {31'd0, eflag});
    chk("rsp_timeout", {31'd0, bus.rsp_timeout},
        {31'd0, tmo});
    held = bus.rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_word1 = $urandom;
      bus.req_nibbles = 3'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, bus.rsp_valid}, 1);
      chk("hold_result", bus.rsp_result, held);
      chk("hold_ready", {31'd0, bus.req_ready}, 0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("post_valid", {31'd0, bus.rsp_valid}, 0);
    chk("post_ready", {31'd0, bus.req_ready}, 1);
  endtask

  initial begin
    alu_cmd_t    cmd;
    logic [31:0] w1;
    logic [31:0] w2;
    int          bad;
    drive_idle();
    rst_n = 1'b0;
    #12;
    chk("rst_ready", {31'd0, bus.req_ready}, 1);
    chk("rst_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_perm", {31'd0, loop_perm_to_count}, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_word1", loop_word1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(CMD_ADD, 1'b0, 3'd0, 32'h00ff0004,
           32'h4, 32'h00ff0004, 0, 1'b0);
    chk("add0_const", bus.rsp_result, 32'h00ff0008);
    do_req(CMD_ADD, 1'b0, 3'd7, 32'h0effffff,
           32'h1, 32'hf0000000, 0, 1'b0);
    chk("add7_const", bus.rsp_result, 32'h0f000000);
    do_req(CMD_XNOR, 1'b0, 3'd7, 32'h12341234,
           32'h12341234, 32'h0, 0, 1'b0);
    chk("eq_flag", {31'd0, bus.rsp_flag}, 1);
    do_req(CMD_XNOR, 1'b0, 3'd7, 32'h22341234,
           32'h12341234, 32'h0, 0, 1'b0);
    chk("neq_flag", {31'd0, bus.rsp_flag}, 0);
    do_req(CMD_ADD, 1'b1, 3'd3, 32'h1234fff0,
           32'h0000000f, 32'hdead0000, 5, 1'b0);

    stuck = 1'b1;
    do_req(CMD_ADD, 1'b0, 3'd2, 32'h111,
           32'h222, 32'h0, 1, 1'b1);
    stuck = 1'b0;

    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_nibbles = 3'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_perm", {31'd0, loop_perm_to_count}, 0);
    chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || loop_perm_to_count)
        bad++;
    end
    chk("no_rsp_after_rst", bad, 0);
    do_req(CMD_ADD, 1'b0, 3'd4, 32'h0001_2345,
           32'h0000_1111, 32'habc0_0000, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      cmd = ($urandom_range(0, 1) == 0) ?
            CMD_ADD : CMD_XNOR;
      w1 = $urandom;
      w2 = $urandom;
      if (cmd == CMD_XNOR) begin
        if ($urandom_range(0, 1) == 0)
          w2 = w1;
        else
          w2 = w1 ^ (32'h1 << $urandom_range(0, 31));
      end
      do_req(cmd, 1'($urandom),
             3'($urandom_range(0, 7)),
             w1, w2, $urandom,
             $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end

endmodule
